// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers: one radix-2 step per
// cycle on operand magnitudes, sign correction applied once at the end.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        hiWe,
    input  logic        loWe,
    input  logic [31:0] dataIn,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic [31:0] a_orig;
    logic [31:0] m;
    logic [31:0] acc;
    logic [31:0] low;

    logic        sgn_in;
    logic        neg_a_in;
    logic        neg_b_in;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] msum;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign busy = (state != IDLE);

    always_comb begin
        sgn_in   = ~op[0];
        neg_a_in = sgn_in & opA[31];
        neg_b_in = sgn_in & opB[31];
        a_abs    = neg_a_in ? (~opA + 32'd1) : opA;
        b_abs    = neg_b_in ? (~opB + 32'd1) : opB;
        // Multiply: {acc,low} shifts right; low[0] selects whether m is added.
        msum     = {1'b0, acc} + (low[0] ? {1'b0, m} : 33'd0);
        // Divide: acc is the partial remainder, low shifts dividend out and quotient in.
        shifted  = {acc, low[31]};
        ge       = (shifted >= {1'b0, m});
        diff     = shifted[31:0] - m;
        prod     = {acc, low};
        prod_fix = (neg_a ^ neg_b) ? (~prod + 64'd1) : prod;
        quot_fix = (neg_a ^ neg_b) ? (~low + 32'd1) : low;
        rem_fix  = neg_a ? (~acc + 32'd1) : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hiWe) hi <= dataIn;
                    if (loWe) lo <= dataIn;
                    if (start) begin
                        is_div   <= op[1];
                        neg_a    <= neg_a_in;
                        neg_b    <= neg_b_in;
                        a_orig   <= opA;
                        div_zero <= (opB == 32'd0);
                        m        <= op[1] ? b_abs : a_abs;
                        low      <= op[1] ? a_abs : b_abs;
                        acc      <= 32'd0;
                        cnt      <= 6'd0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc <= ge ? diff : shifted[31:0];
                        low <= {low[30:0], ge};
                    end else begin
                        acc <= msum[32:1];
                        low <= {msum[0], low[31:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FINISH;
                end
                FINISH: begin
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (div_zero) begin
                        hi <= a_orig;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: scoreboard of expected {hi,lo} words from an arithmetic
// reference model, checked when done pulses.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        hiWe;
    logic        loWe;
    logic [31:0] dataIn;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [63:0] e;
    int          bc;
    bit          got;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    localparam logic [1:0]  M_OP [5] = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULT, OP_MULTU};
    localparam logic [31:0] M_A  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
    localparam logic [31:0] M_B  [5] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd1, 32'h9ABCDEF0};

    localparam logic [1:0]  D_OP [8] = '{OP_DIV, OP_DIVU, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    localparam logic [31:0] D_A  [8] = '{32'hFFFFFFF9, 32'd7, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd0};
    localparam logic [31:0] D_B  [8] = '{32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd1, 32'd5};

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .hiWe(hiWe), .loWe(loWe), .dataIn(dataIn),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        logic [63:0] r;
        case (o)
            OP_MULT: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                r  = sa * sb;
            end
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                qa = a;
                qb = b;
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else r = {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        opA   = a;
        opB   = b;
        start = 1'b1;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(output int busy_cyc, output bit seen);
        busy_cyc = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        // reset wins over a coincident start and write
        start = 1'b1; hiWe = 1'b1; dataIn = 32'h1234; op = OP_MULTU; opA = 32'd3; opB = 32'd3;
        @(negedge clk);
        start = 1'b0; hiWe = 1'b0; rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_prio_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_prio_hi got=%h exp=0", hi); end
    endtask

    task automatic test_mult();
        for (int i = 0; i < 5; i++) begin
            issue(M_OP[i], M_A[i], M_B[i]);
            wait_result(bc, got);
            e = exp_q.pop_front();
            checks++; if (got !== 1'b1) begin failures++; $display("FAIL mult[%0d]_done got=%b exp=1", i, got); end
            checks++; if (bc != 33) begin failures++; $display("FAIL mult[%0d]_busy_cycles got=%0d exp=33", i, bc); end
            checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL mult[%0d]_hilo got=%h exp=%h", i, {hi, lo}, e); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult[%0d]_done_width got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div();
        for (int i = 0; i < 8; i++) begin
            issue(D_OP[i], D_A[i], D_B[i]);
            wait_result(bc, got);
            e = exp_q.pop_front();
            checks++; if (got !== 1'b1) begin failures++; $display("FAIL div[%0d]_done got=%b exp=1", i, got); end
            checks++; if (bc != 33) begin failures++; $display("FAIL div[%0d]_busy_cycles got=%0d exp=33", i, bc); end
            checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL div[%0d]_hilo got=%h exp=%h", i, {hi, lo}, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int dones;
        op = OP_MULTU; opA = 32'd5; opB = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL abort_hilo got=%h exp=0", {hi, lo}); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_result(bc, got);
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL abort_next_done got=%b exp=1", got); end
        checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL abort_next_hilo got=%h exp=%h", {hi, lo}, e); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        pre_hi = hi;
        pre_lo = lo;
        issue(OP_MULTU, 32'h1234, 32'h10);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; opA = 32'd100; opB = 32'd7;
        loWe = 1'b1; hiWe = 1'b1; dataIn = 32'd9;
        @(negedge clk);
        start = 1'b0; loWe = 1'b0; hiWe = 1'b0;
        checks++; if ({hi, lo} !== {pre_hi, pre_lo}) begin failures++; $display("FAIL busy_hold_hilo got=%h exp=%h", {hi, lo}, {pre_hi, pre_lo}); end
        wait_result(bc, got);
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL busy_ign_done got=%b exp=1", got); end
        checks++; if (bc != 31) begin failures++; $display("FAIL busy_ign_cycles got=%0d exp=31", bc); end
        checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL busy_ign_hilo got=%h exp=%h", {hi, lo}, e); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_ign_no_restart got=%b exp=0", busy); end
        loWe = 1'b1; dataIn = 32'd9;
        @(negedge clk);
        loWe = 1'b0;
        checks++; if (lo !== 32'd9) begin failures++; $display("FAIL mtlo got=%h exp=9", lo); end
        checks++; if (hi !== e[63:32]) begin failures++; $display("FAIL mtlo_hi_keep got=%h exp=%h", hi, e[63:32]); end
        hiWe = 1'b1; dataIn = 32'h55;
        @(negedge clk);
        hiWe = 1'b0;
        checks++; if ({hi, lo} !== {32'h55, 32'd9}) begin failures++; $display("FAIL mthi got=%h exp=%h", {hi, lo}, {32'h55, 32'd9}); end
    endtask

    task automatic test_write_with_start();
        hiWe = 1'b1; loWe = 1'b1; dataIn = 32'hAAAA;
        issue(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA);
        hiWe = 1'b0; loWe = 1'b0;
        checks++; if ({hi, lo} !== {32'hAAAA, 32'hAAAA}) begin failures++; $display("FAIL wr_start_hilo got=%h exp=%h", {hi, lo}, {32'hAAAA, 32'hAAAA}); end
        wait_result(bc, got);
        e = exp_q.pop_front();
        checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL wr_start_result got=%h exp=%h", {hi, lo}, e); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i == 3) b = 32'd3;
            issue(2'($urandom_range(0, 3)), a, b);
            wait_result(bc, got);
            e = exp_q.pop_front();
            checks++; if (got !== 1'b1) begin failures++; $display("FAIL b2b[%0d]_done got=%b exp=1", i, got); end
            checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b[%0d]_hilo got=%h exp=%h", i, {hi, lo}, e); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; opA = 32'd0; opB = 32'd0;
        hiWe = 1'b0; loWe = 1'b0; dataIn = 32'd0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_abort();
        test_busy_ignore();
        test_write_with_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: MulDivUnit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new operation; sampled at the clk edge
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opA  input  32  multiplicand or dividend (register file outA)
- opB  input  32  multiplier or divisor (register file outB)
- hiWe  input  1  MTHI write enable
- loWe  input  1  MTLO write enable
- dataIn  input  32  MTHI/MTLO write data
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- hi  output  32  HI register (product high word or remainder)
- lo  output  32  LO register (product low word or quotient)

Function
REQ-004 The block SHALL implement FSM states IDLE, RUN and FINISH; busy SHALL equal (state != IDLE).
REQ-005 At an edge E0 with state==IDLE, start==1 and rst==0, the block SHALL:
- latch op, opA and opB
- clear the 6-bit iteration counter
- enter RUN
REQ-006 In RUN, each edge SHALL perform one radix-2 iteration (shift-add for multiply, restoring shift-subtract for divide) on operand magnitudes and increment the counter; the 32nd RUN edge (E32) SHALL enter FINISH.
REQ-007 At the FINISH edge (E33), the block SHALL:
- apply sign correction
- write hi and lo
- set done=1 for exactly the one cycle after E33
- return to IDLE
REQ-008 busy SHALL be high for exactly 33 cycles (E0 to E33); a start sampled in the done cycle SHALL be accepted.
REQ-009 start while busy==1 SHALL be ignored; latched operands SHALL NOT change.
REQ-010 MULT/MULTU SHALL produce {hi,lo} equal to the full 64-bit two's-complement signed or unsigned product.
REQ-011 DIV/DIVU SHALL set lo=quotient and hi=remainder; signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-012 When the divisor is 0 (DIV or DIVU), the block SHALL set lo=32'hFFFFFFFF and hi=opA, and SHALL still take full latency.
REQ-013 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL set lo=32'h80000000 and hi=0.
REQ-014 hi/lo SHALL hold their previous values throughout RUN and FINISH until the E33 update.
REQ-015 hiWe/loWe SHALL load dataIn into hi/lo at the edge only when state==IDLE, and SHALL be ignored otherwise.
REQ-016 When start and hiWe/loWe coincide in IDLE, the write SHALL take effect and the operation SHALL also start; the operation's later result SHALL overwrite hi/lo.

Reset
REQ-017 rst==1 at an edge SHALL force:
- state=IDLE, counter=0
- hi=0, lo=0
- busy=0, done=0
REQ-018 rst SHALL take priority over start, hiWe, loWe and FINISH.
REQ-019 rst mid-operation SHALL abort the operation: no done pulse and no result write.

Verification
REQ-020 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; done high only in the cycle after E33; busy high for 33 cycles.
REQ-021 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-022 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1.
REQ-023 DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=32'h00000064; DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-024 Start MULTU 5 x 5 from reset, then assert rst at E10 -> busy=0 from the next cycle, no done pulse, hi=lo=0; then start MULTU 2 x 3 -> lo=6, hi=0.
REQ-025 Start while busy, plus loWe=1 with dataIn=9 during RUN -> both ignored, original result delivered; loWe=1 with dataIn=9 in IDLE -> lo=9 on the next cycle.
